// File: rtl/router_pkg.sv
`default_nettype none
// ==========================================================================
// router_pkg : flit types, injector states, header field offsets | rev 1.0
// ==========================================================================
package router_pkg;

    typedef enum logic [1:0] {
        FLIT_BODY     = 2'b00,
        FLIT_TAIL     = 2'b01,
        FLIT_HEAD     = 2'b10,
        FLIT_HEADTAIL = 2'b11
    } flit_type_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HEAD = 2'd1,
        S_BODY = 2'd2
    } inj_state_t;

    // Header layout from LSB: len, dst_y, dst_x, dy, dx; upper bits zero.
    localparam int HDR_LEN_LSB = 0;

    function automatic int hdr_ydst_lsb(input int len_w);
        return HDR_LEN_LSB + len_w;
    endfunction

    function automatic int hdr_xdst_lsb(input int len_w, input int y_w);
        return HDR_LEN_LSB + len_w + y_w;
    endfunction

    function automatic int hdr_dy_bit(input int len_w, input int y_w, input int x_w);
        return HDR_LEN_LSB + len_w + y_w + x_w;
    endfunction

    function automatic int hdr_dx_bit(input int len_w, input int y_w, input int x_w);
        return HDR_LEN_LSB + len_w + y_w + x_w + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/router_hdr_enc.sv
`default_nettype none
// ==========================================================================
// router_hdr_enc : combinational routing-header encoder (dx/dy, is_self)
// rev 1.0
// ==========================================================================
module router_hdr_enc
    import router_pkg::*;
#(
    parameter int maxx   = 2,
    parameter int maxy   = 2,
    parameter int LEN_W  = 4,
    parameter int DATA_W = 32
) (
    input  logic [maxx-1:0]   dst_x_i,
    input  logic [maxy-1:0]   dst_y_i,
    input  logic [maxx-1:0]   self_x_i,
    input  logic [maxy-1:0]   self_y_i,
    input  logic [LEN_W-1:0]  len_i,
    output logic [DATA_W-1:0] hdr_o,
    output logic              dx_o,
    output logic              dy_o,
    output logic              is_self_o
);

    localparam int Y_LSB  = hdr_ydst_lsb(LEN_W);
    localparam int X_LSB  = hdr_xdst_lsb(LEN_W, maxy);
    localparam int DY_BIT = hdr_dy_bit(LEN_W, maxy, maxx);
    localparam int DX_BIT = hdr_dx_bit(LEN_W, maxy, maxx);

    assign dx_o      = (dst_x_i > self_x_i);
    assign dy_o      = (dst_y_i > self_y_i);
    assign is_self_o = (dst_x_i == self_x_i) && (dst_y_i == self_y_i);

    always_comb begin
        hdr_o                          = '0;
        hdr_o[HDR_LEN_LSB +: LEN_W]    = len_i;
        hdr_o[Y_LSB +: maxy]           = dst_y_i;
        hdr_o[X_LSB +: maxx]           = dst_x_i;
        hdr_o[DY_BIT]                  = dy_o;
        hdr_o[DX_BIT]                  = dx_o;
    end

endmodule
`default_nettype wire

// File: rtl/router_injector.sv
`default_nettype none
// ==========================================================================
// router_injector : source NI, builds header and emits HEAD/BODY/TAIL flits
// Optional INJ_STATS_EN adds packet/flit handshake counters. rev 1.0
// ==========================================================================
module router_injector
    import router_pkg::*;
#(
    parameter int maxx   = 2,
    parameter int maxy   = 2,
    parameter int selfx  = 2,
    parameter int selfy  = 2,
    parameter int LEN_W  = 4,
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [maxx-1:0]   dst_x_i,
    input  logic [maxy-1:0]   dst_y_i,
    input  logic [LEN_W-1:0]  len_i,
    input  logic              pld_valid_i,
    output logic              pld_ready_o,
    input  logic [DATA_W-1:0] pld_data_i,
    output logic              flit_valid_o,
    input  logic              flit_ready_i,
    output logic [DATA_W+1:0] flit_o,
`ifdef INJ_STATS_EN
    output logic [15:0]       pkt_cnt_o,
    output logic [15:0]       flit_cnt_o,
`endif
    output logic              err_self_o
);

    localparam logic [maxx-1:0] SELF_X = maxx'(selfx);
    localparam logic [maxy-1:0] SELF_Y = maxy'(selfy);

    inj_state_t        state_q, state_d;
    logic [LEN_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] hdr_q, hdr_d;
    logic              err_q, err_d;

    logic [DATA_W-1:0] enc_hdr;
    logic              enc_dx, enc_dy, enc_self;
    logic              unused_dir;
    logic              req_ready_w;
    logic [LEN_W-1:0]  hdr_len;

    router_hdr_enc #(
        .maxx   (maxx),
        .maxy   (maxy),
        .LEN_W  (LEN_W),
        .DATA_W (DATA_W)
    ) u_hdr_enc (
        .dst_x_i   (dst_x_i),
        .dst_y_i   (dst_y_i),
        .self_x_i  (SELF_X),
        .self_y_i  (SELF_Y),
        .len_i     (len_i),
        .hdr_o     (enc_hdr),
        .dx_o      (enc_dx),
        .dy_o      (enc_dy),
        .is_self_o (enc_self)
    );

    // Direction bits already live inside enc_hdr.
    assign unused_dir = enc_dx ^ enc_dy;
    assign hdr_len    = hdr_q[HDR_LEN_LSB +: LEN_W];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            count_q <= '0;
            hdr_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            hdr_q   <= hdr_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        hdr_d        = hdr_q;
        err_d        = 1'b0;
        req_ready_w  = 1'b0;
        pld_ready_o  = 1'b0;
        flit_valid_o = 1'b0;
        flit_o       = '0;
        case (state_q)
            S_IDLE: begin
                req_ready_w = 1'b1;
                if (req_valid_i) begin
                    hdr_d = enc_hdr;
                    if (enc_self) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = S_HEAD;
                    end
                end
            end
            S_HEAD: begin
                flit_valid_o = 1'b1;
                flit_o       = {(hdr_len == '0) ? FLIT_HEADTAIL : FLIT_HEAD, hdr_q};
                if (flit_ready_i) begin
                    if (hdr_len == '0) begin
                        state_d = S_IDLE;
                    end else begin
                        count_d = hdr_len;
                        state_d = S_BODY;
                    end
                end
            end
            S_BODY: begin
                flit_valid_o = pld_valid_i;
                pld_ready_o  = flit_ready_i;
                flit_o       = {(count_q == LEN_W'(1)) ? FLIT_TAIL : FLIT_BODY, pld_data_i};
                if (pld_valid_i && flit_ready_i) begin
                    count_d = count_q - LEN_W'(1);
                    if (count_q == LEN_W'(1)) begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Keep the request side closed while reset is asserted.
    assign req_ready_o = req_ready_w & rst_ni;
    assign err_self_o  = err_q;

`ifdef INJ_STATS_EN
    logic [15:0] pkt_cnt_q, flit_cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pkt_cnt_q  <= '0;
            flit_cnt_q <= '0;
        end else begin
            if (state_q == S_HEAD && flit_ready_i) begin
                pkt_cnt_q <= pkt_cnt_q + 16'd1;
            end
            if (flit_valid_o && flit_ready_i) begin
                flit_cnt_q <= flit_cnt_q + 16'd1;
            end
        end
    end

    assign pkt_cnt_o  = pkt_cnt_q;
    assign flit_cnt_o = flit_cnt_q;
`endif

endmodule
`default_nettype wire
